// File: rtl/pipelined_control_unit_if.sv
// ID-stage instruction fields into the control unit and the registered ID/EX control bundle out.
// master drives the ID side; slave is the control unit.
interface pipelined_control_unit_if #(
  parameter int OPW  = 6,
  parameter int REGW = 5
);
  logic [OPW-1:0]  opcode1;
  logic            valid_in;
  logic [REGW-1:0] rs;
  logic [REGW-1:0] rt;
  logic [REGW-1:0] rd;
  logic            redirect;

  logic [1:0]      alusrc;
  logic [1:0]      newpcsrc;
  logic            memwe;
  logic            memre;
  logic            regwe;
  logic [1:0]      regwrsrcsel;
  logic            regwrdstsel;
  logic [REGW-1:0] dstreg;
  logic            valid_out;
  logic            stall;
  logic            illegal;

  modport master (
    output opcode1, valid_in, rs, rt, rd, redirect,
    input  alusrc, newpcsrc, memwe, memre, regwe, regwrsrcsel, regwrdstsel,
           dstreg, valid_out, stall, illegal
  );

  modport slave (
    input  opcode1, valid_in, rs, rt, rd, redirect,
    output alusrc, newpcsrc, memwe, memre, regwe, regwrsrcsel, regwrdstsel,
           dstreg, valid_out, stall, illegal
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// ID decode into a registered ID/EX control bundle (1-cycle latency), with load-use stall,
// post-redirect squash of FLUSH_CYCLES slots and illegal-opcode bubbles.
module pipelined_control_unit #(
  parameter int OPW          = 6,
  parameter int REGW         = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pipelined_control_unit_if.slave io_bus
);

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

  // Counter holds the number of squash slots still owed after the current edge.
  localparam logic [2:0] LP_CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;

  logic [1:0]      r_alusrc, r_newpcsrc, r_regwrsrcsel;
  logic            r_memwe, r_memre, r_regwe, r_regwrdstsel;
  logic [REGW-1:0] r_dstreg;
  logic            r_valid, r_illegal;

  logic [5:0]      w_op_lo;
  logic            w_hi_zero;
  logic            w_legal;
  logic [1:0]      w_alusrc, w_newpcsrc, w_regwrsrcsel;
  logic            w_memwe, w_memre, w_regwe, w_regwrdstsel;
  logic            w_hazard, w_stall, w_issue, w_load, w_ill_nxt;

  assign w_op_lo   = io_bus.opcode1[5:0];
  assign w_hi_zero = ((io_bus.opcode1 >> 6) == '0);

  always_comb begin
    w_legal       = 1'b0;
    w_alusrc      = 2'b00;
    w_newpcsrc    = 2'b00;
    w_memwe       = 1'b0;
    w_memre       = 1'b0;
    w_regwe       = 1'b0;
    w_regwrsrcsel = 2'b00;
    w_regwrdstsel = 1'b0;
    if (w_hi_zero) begin
      case (w_op_lo)
        6'b000000: begin
          w_legal = 1'b1; w_regwrsrcsel = 2'b10; w_regwrdstsel = 1'b1; w_regwe = 1'b1;
        end
        6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
          w_legal = 1'b1; w_newpcsrc = 2'b11;
        end
        6'b001100: begin
          w_legal = 1'b1; w_alusrc = 2'b10; w_newpcsrc = 2'b01; w_regwe = 1'b1;
        end
        6'b010010: begin
          w_legal = 1'b1; w_alusrc = 2'b01; w_memre = 1'b1; w_regwe = 1'b1;
          w_regwrsrcsel = 2'b01;
        end
        6'b011010: begin
          w_legal = 1'b1; w_alusrc = 2'b01; w_memwe = 1'b1;
        end
        6'b100000, 6'b100100, 6'b100101, 6'b100110: begin
          w_legal = 1'b1; w_alusrc = 2'b01; w_regwe = 1'b1; w_regwrsrcsel = 2'b10;
        end
        default: w_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (io_bus.redirect) begin
      w_state_nxt = (LP_CNT_INIT != 3'd0) ? S_FLUSH : S_RUN;
      w_cnt_nxt   = LP_CNT_INIT;
    end else if (r_state == S_FLUSH) begin
      w_cnt_nxt = r_cnt - 3'd1;
      if (r_cnt <= 3'd1) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 3'd0;
      end
    end
  end

  // A redirect squashes the ID instruction anyway, so it suppresses the stall.
  always_comb begin
    w_hazard  = (r_state == S_RUN) && r_valid && r_memre && (r_dstreg != '0) &&
                io_bus.valid_in &&
                ((io_bus.rs == r_dstreg) || (io_bus.rt == r_dstreg));
    w_stall   = w_hazard && !io_bus.redirect;
    w_issue   = (r_state == S_RUN) && !io_bus.redirect && io_bus.valid_in && !w_stall;
    w_load    = w_issue && w_legal;
    w_ill_nxt = w_issue && !w_legal;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alusrc      <= 2'b00;
      r_newpcsrc    <= 2'b00;
      r_memwe       <= 1'b0;
      r_memre       <= 1'b0;
      r_regwe       <= 1'b0;
      r_regwrsrcsel <= 2'b00;
      r_regwrdstsel <= 1'b0;
      r_dstreg      <= '0;
      r_valid       <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_alusrc      <= w_load ? w_alusrc      : 2'b00;
      r_newpcsrc    <= w_load ? w_newpcsrc    : 2'b00;
      r_memwe       <= w_load ? w_memwe       : 1'b0;
      r_memre       <= w_load ? w_memre       : 1'b0;
      r_regwe       <= w_load ? w_regwe       : 1'b0;
      r_regwrsrcsel <= w_load ? w_regwrsrcsel : 2'b00;
      r_regwrdstsel <= w_load ? w_regwrdstsel : 1'b0;
      r_dstreg      <= w_load ? (w_regwrdstsel ? io_bus.rd : io_bus.rt) : '0;
      r_valid       <= w_load;
      r_illegal     <= w_ill_nxt;
    end
  end

  assign io_bus.alusrc      = r_alusrc;
  assign io_bus.newpcsrc    = r_newpcsrc;
  assign io_bus.memwe       = r_memwe;
  assign io_bus.memre       = r_memre;
  assign io_bus.regwe       = r_regwe;
  assign io_bus.regwrsrcsel = r_regwrsrcsel;
  assign io_bus.regwrdstsel = r_regwrdstsel;
  assign io_bus.dstreg      = r_dstreg;
  assign io_bus.valid_out   = r_valid;
  assign io_bus.stall       = w_stall;
  assign io_bus.illegal     = r_illegal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Drives two control units (FLUSH_CYCLES 2 and 3) with the same ID stream and checks
// both against a slot-level reference model of decode, stall, squash and illegal flagging.
module tb_pipelined_control_unit;
  localparam int OPW  = 6;
  localparam int REGW = 5;

  typedef struct packed {
    logic [1:0]      alusrc;
    logic [1:0]      newpcsrc;
    logic            memwe;
    logic            memre;
    logic            regwe;
    logic [1:0]      wsrc;
    logic            dst;
    logic [REGW-1:0] dstreg;
    logic            valid;
    logic            illegal;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [OPW-1:0]  d_op = '0;
  logic            d_vld = 1'b0;
  logic [REGW-1:0] d_rs = '0, d_rt = '0, d_rd = '0;
  logic            d_redir = 1'b0;

  pipelined_control_unit_if #(.OPW(OPW), .REGW(REGW)) bus2 ();
  pipelined_control_unit_if #(.OPW(OPW), .REGW(REGW)) bus3 ();

  assign bus2.opcode1 = d_op;  assign bus3.opcode1 = d_op;
  assign bus2.valid_in = d_vld; assign bus3.valid_in = d_vld;
  assign bus2.rs = d_rs;       assign bus3.rs = d_rs;
  assign bus2.rt = d_rt;       assign bus3.rt = d_rt;
  assign bus2.rd = d_rd;       assign bus3.rd = d_rd;
  assign bus2.redirect = d_redir; assign bus3.redirect = d_redir;

  pipelined_control_unit #(.OPW(OPW), .REGW(REGW), .FLUSH_CYCLES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus2.slave));
  pipelined_control_unit #(.OPW(OPW), .REGW(REGW), .FLUSH_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus3.slave));

  int checks = 0;
  int errors = 0;

  ctl_t m_out [2];
  int   m_left [2];
  int   fc [2];

  logic [OPW-1:0] legal_ops [12];

  // {legal, alusrc, newpcsrc, memwe, memre, regwe, wsrc, dst}
  function automatic logic [10:0] ref_decode(input logic [OPW-1:0] op);
    case (op)
      6'b000000: return {1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1};
      6'b001000, 6'b001001, 6'b001010, 6'b001011:
                 return {1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      6'b001100: return {1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
      6'b010010: return {1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
      6'b011010: return {1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
      6'b100000, 6'b100100, 6'b100101, 6'b100110:
                 return {1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
      default:   return 11'd0;
    endcase
  endfunction

  function automatic ctl_t obs(input int k);
    if (k == 0)
      return {bus2.alusrc, bus2.newpcsrc, bus2.memwe, bus2.memre, bus2.regwe,
              bus2.regwrsrcsel, bus2.regwrdstsel, bus2.dstreg, bus2.valid_out, bus2.illegal};
    else
      return {bus3.alusrc, bus3.newpcsrc, bus3.memwe, bus3.memre, bus3.regwe,
              bus3.regwrsrcsel, bus3.regwrdstsel, bus3.dstreg, bus3.valid_out, bus3.illegal};
  endfunction

  function automatic logic obs_stall(input int k);
    return (k == 0) ? bus2.stall : bus3.stall;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = '0;
      m_left[k] = 0;
    end
  endtask

  // One ID slot: drive inputs, check combinational stall, clock, check the registered bundle.
  task automatic slot(input logic [OPW-1:0] op, input logic v, input logic [REGW-1:0] rs,
                      input logic [REGW-1:0] rt, input logic [REGW-1:0] rd,
                      input logic redir, input string tag);
    ctl_t nxt [2];
    int   nl [2];
    d_op = op; d_vld = v; d_rs = rs; d_rt = rt; d_rd = rd; d_redir = redir;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic hz, st;
      logic [10:0] dec;
      hz = (m_left[k] == 0) && m_out[k].valid && m_out[k].memre && (m_out[k].dstreg != 0) &&
           v && ((rs == m_out[k].dstreg) || (rt == m_out[k].dstreg));
      st = hz && !redir;
      check($sformatf("%s_stall_fc%0d", tag, fc[k]), 32'(obs_stall(k)), 32'(st));
      nxt[k] = '0;
      nl[k]  = m_left[k];
      if (redir) nl[k] = fc[k] - 1;
      else if (nl[k] > 0) nl[k] = nl[k] - 1;
      else if (v && !st) begin
        dec = ref_decode(op);
        if (dec[10]) nxt[k] = {dec[9:0], (dec[0] ? rd : rt), 1'b1, 1'b0};
        else nxt[k].illegal = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = nxt[k];
      m_left[k] = nl[k];
      check($sformatf("%s_out_fc%0d", tag, fc[k]), 32'(obs(k)), 32'(m_out[k]));
    end
  endtask

  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_rst_out_fc%0d", tag, fc[k]), 32'(obs(k)), 32'd0);
      check($sformatf("%s_rst_stall_fc%0d", tag, fc[k]), 32'(obs_stall(k)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [OPW-1:0] ALUR = 6'b000000;
  localparam logic [OPW-1:0] LW   = 6'b010010;
  localparam logic [OPW-1:0] ADDI = 6'b100000;

  initial begin
    ctl_t exp_addi;
    fc[0] = 2; fc[1] = 3;
    legal_ops = '{6'b000000, 6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100,
                  6'b010010, 6'b011010, 6'b100000, 6'b100100, 6'b100101, 6'b100110};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("reset_fc%0d", fc[k]), 32'(obs(k)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-cycle with ALUR loaded, then ADDI RT=3 against a hand-built bundle.
    slot(ALUR, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, "alur_pre_rst");
    mid_reset("alur");
    slot(ADDI, 1'b1, 5'd0, 5'd3, 5'd9, 1'b0, "addi_post_rst");
    exp_addi = '{alusrc: 2'b01, newpcsrc: 2'b00, memwe: 1'b0, memre: 1'b0, regwe: 1'b1,
                 wsrc: 2'b10, dst: 1'b0, dstreg: 5'd3, valid: 1'b1, illegal: 1'b0};
    check("addi_literal", 32'(obs(0)), 32'(exp_addi));

    // Opcode sweep, then an illegal opcode and a gap to confirm a single-cycle pulse.
    for (int i = 0; i < 12; i++)
      slot(legal_ops[i], 1'b1, 5'(i), 5'(i + 1), 5'(i + 2), 1'b0, $sformatf("sweep%0d", i));
    slot(6'b111111, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, "illegal");
    check("illegal_pulse", 32'(bus2.illegal), 32'd1);
    slot(ALUR, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, "illegal_gap");
    check("illegal_drop", 32'(bus2.illegal), 32'd0);

    // Load-use on r5: stall, bubble, re-decode of the held ADD.
    slot(LW,   1'b1, 5'd1, 5'd5, 5'd0, 1'b0, "lu_lw");
    slot(ALUR, 1'b1, 5'd5, 5'd6, 5'd8, 1'b0, "lu_add_stalled");
    check("lu_bubble", 32'(bus2.valid_out), 32'd0);
    slot(ALUR, 1'b1, 5'd5, 5'd6, 5'd8, 1'b0, "lu_add_issue");
    check("lu_add_dst", 32'(bus2.regwrdstsel), 32'd1);

    // Register 0 never creates a hazard.
    slot(LW,   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, "lu0_lw");
    slot(ALUR, 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, "lu0_add");

    // Redirect with ALUR held: FLUSH_CYCLES bubbles then ALUR.
    slot(ALUR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, "redir");
    for (int i = 0; i < 4; i++) slot(ALUR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, $sformatf("redir_h%0d", i));

    // Redirect coinciding with a load-use hazard, then a second redirect mid-flush.
    slot(LW,   1'b1, 5'd1, 5'd5, 5'd0, 1'b0, "rp_lw");
    slot(ALUR, 1'b1, 5'd5, 5'd6, 5'd8, 1'b1, "rp_redir_hz");
    slot(ALUR, 1'b1, 5'd5, 5'd6, 5'd8, 1'b1, "rp_redir2");
    for (int i = 0; i < 4; i++) slot(ALUR, 1'b1, 5'd5, 5'd6, 5'd8, 1'b0, $sformatf("rp_h%0d", i));

    // Reset mid-flush returns to RUN.
    slot(ALUR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, "mf_redir");
    mid_reset("midflush");
    slot(ALUR, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, "mf_post_rst");

    // Randomized ID stream with narrow register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [OPW-1:0] op;
      op = ($urandom_range(0, 9) == 0) ? OPW'($urandom) : legal_ops[$urandom_range(0, 11)];
      slot(op, ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation control generator for the 5-stage core. It decodes the primary opcode in ID and registers the full control bundle into the ID/EX stage. It detects load-use hazards and inserts stall bubbles, and squashes wrong-path instructions for a parametrised number of cycles after a taken branch or JAL. Unknown opcodes are flagged and turned into bubbles instead of leaving outputs latched.

Parameters:
OPW, 6, primary opcode width (encodings occupy the low 6 bits; upper bits must be 0 for a legal decode)
REGW, 5, register index width
FLUSH_CYCLES, 2, bubbles inserted after a redirect (1..7)

Ports:
CLOCK  input  1  core clock, rising edge
RESET_N  input  1  asynchronous active-low reset
OPCODE1_IN  input  OPW  opcode of instruction in ID
VALID_IN  input  1  ID holds a real instruction
RS_IN  input  REGW  source register 1 of ID instruction
RT_IN  input  REGW  source register 2 / I-type destination
RD_IN  input  REGW  R-type destination
REDIRECT_IN  input  1  EX resolved taken branch or JAL this cycle
ALUSRC_OUT  output  2  registered ID/EX control
NEWPCSRC_OUT  output  2  registered ID/EX control
MEMWE_OUT  output  1  registered ID/EX control
MEMRE_OUT  output  1  registered ID/EX control
REGWE_OUT  output  1  registered ID/EX control
REGWRSRCSEL_OUT  output  2  registered ID/EX control
REGWRDSTSEL_OUT  output  1  registered ID/EX control
DSTREG_OUT  output  REGW  registered destination register (RD_IN if REGWRDSTSEL=1, else RT_IN)
VALID_OUT  output  1  ID/EX slot holds a real instruction
STALL_OUT  output  1  combinational; hold PC and IF/ID this cycle
ILLEGAL_OUT  output  1  one-cycle registered pulse on an illegal opcode

Behaviour:
- Decode table:
  - ALUR 000000: ALUSRC 00, NEWPCSRC 00, WSRC 10, DST 1, REGWE 1.
  - BEQ/BLT/BLE/BNE 001000..001011: ALUSRC 00, NEWPCSRC 11, REGWE 0.
  - JAL 001100: ALUSRC 10, NEWPCSRC 01, REGWE 1, WSRC 00.
  - LW 010010: ALUSRC 01, MEMRE 1, REGWE 1, WSRC 01.
  - SW 011010: ALUSRC 01, MEMWE 1.
  - ADDI/ANDI/ORI/XORI 100000/100100/100101/100110: ALUSRC 01, REGWE 1, WSRC 10.
  - Any unlisted field is 0.
- Bubble: all control outputs 0, DSTREG 0, VALID_OUT 0.
- Reset, asynchronous: all outputs 0; state RUN; flush counter 0.
- States: RUN, FLUSH. Latency: decode of the ID instruction appears on outputs 1 cycle later.
- Load-use hazard (RUN only), evaluated every cycle: VALID_OUT=1, MEMRE_OUT=1, DSTREG_OUT!=0, VALID_IN=1, and (RS_IN==DSTREG_OUT or RT_IN==DSTREG_OUT).
  - STALL_OUT=1 combinationally.
  - Next cycle loads a bubble; the ID instruction is held upstream and re-decoded.
  - Register 0 never causes a hazard.
- REDIRECT_IN=1 in any state:
  - Next edge loads a bubble.
  - State becomes FLUSH with counter = FLUSH_CYCLES-1.
  - STALL_OUT is forced 0 that cycle; redirect beats hazard.
- FLUSH: every edge loads a bubble and the counter decrements. When the counter is 0, the next edge returns to RUN and loads a bubble for that final slot. Total bubbles = FLUSH_CYCLES. A REDIRECT_IN arriving during FLUSH reloads the counter.
- VALID_IN=0 in RUN: load a bubble, no hazard.
- Illegal opcode (VALID_IN=1, no table match, including nonzero upper bits when OPW>6): load a bubble and pulse ILLEGAL_OUT for 1 cycle. No ILLEGAL_OUT pulse in FLUSH or while stalled.
- Asserting RESET_N low mid-FLUSH or mid-stall immediately zeroes all outputs. After release the block resumes in RUN.

Test Plan:
- Reset: assert RESET_N=0 mid-cycle with ALUR loaded -> all outputs 0 immediately. Release, drive ADDI (100000) with RT=3 -> next cycle ALUSRC=01, REGWE=1, WSRC=10, DST=0, DSTREG=3, VALID_OUT=1.
- Opcode sweep: drive each of the 12 legal opcodes back-to-back -> outputs match the decode table 1 cycle later, ILLEGAL_OUT stays 0. Opcode 111111 -> bubble plus ILLEGAL_OUT high for exactly 1 cycle.
- Load-use: LW with RT=5, then ADD with RS=5 -> STALL_OUT=1 in the ADD cycle, one bubble, then ADD decoded (REGWRDSTSEL=1).
- Load-use, no stall: same sequence with RS=RT=0 and LW dest 0 -> no stall.
- Redirect: REDIRECT_IN pulse, FLUSH_CYCLES=2, ALUR held on input -> exactly 2 bubbles, then ALUR appears. With FLUSH_CYCLES=3 -> 3 bubbles.
- Redirect priority: REDIRECT_IN in the same cycle as a load-use hazard -> STALL_OUT=0 and a FLUSH_CYCLES bubble sequence. A second REDIRECT_IN mid-flush restarts the count; asserting RESET_N low mid-flush -> RUN with zeroed outputs.
